// File: rtl/bbc_slow_cycle_ctrl_if.sv
// Handshake and bus-enable bundle between the 65816 glue (master) and the
// BBC slow-cycle sequencer (slave).
interface bbc_slow_cycle_ctrl_if;
  logic req;
  logic req_rnw;
  logic err_clr;
  logic cpu_stall;
  logic bbc_cycle_en;
  logic bbc_wdata_oe;
  logic rdata_le;
  logic done;
  logic timeout;
  logic err;

  modport master (
    output req, req_rnw, err_clr,
    input  cpu_stall, bbc_cycle_en, bbc_wdata_oe, rdata_le, done, timeout, err
  );

  modport slave (
    input  req, req_rnw, err_clr,
    output cpu_stall, bbc_cycle_en, bbc_wdata_oe, rdata_le, done, timeout, err
  );
endinterface

// File: rtl/bbc_slow_cycle_ctrl.sv
// BBC slow-cycle sequencer: while the 65816 runs from hsclk, this block stalls
// the CPU clock, waits for the start of a BBC phi1 and then drives one real
// bus cycle for a full phi0 period, with a watchdog that aborts the access if
// phi0 stops toggling.
module bbc_slow_cycle_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                  hsclk,
  input  logic                  resetb,
  input  logic                  bbc_phi0,
  bbc_slow_cycle_ctrl_if.slave  bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   phi0_s;
  logic                   phi0_d;
  logic                   fall;
  logic                   rise;

  logic [2:0]             state_q;
  logic [2:0]             state_n;
  logic                   rnw_q;
  logic [TO_W-1:0]        count_q;
  logic                   at_limit;
  logic                   to_hit;
  logic                   timeout_q;
  logic                   err_q;

  logic                   active;
  logic                   in_addr;
  logic                   in_data;
  logic                   in_done;

  assign phi0_s   = sync_q[SYNC_STAGES-1];
  assign fall     = phi0_d & ~phi0_s;
  assign rise     = ~phi0_d & phi0_s;
  assign at_limit = (count_q == TO_W'(TIMEOUT_CYC - 1));

  assign in_addr  = (state_q == ST_ADDR);
  assign in_data  = (state_q == ST_DATA);
  assign in_done  = (state_q == ST_DONE);
  assign active   = (state_q == ST_ARM) | in_addr | in_data;

  // Bring the asynchronous phi0 into hsclk and keep one extra sample for edge detection
  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      sync_q <= '0;
      phi0_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bbc_phi0};
      phi0_d <= phi0_s;
    end
  end

  // Next-state decode: follow phi0 edges through one bus cycle, bail out to DONE when the watchdog expires
  always_comb begin
    state_n = state_q;
    to_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) state_n = ST_ARM;
      end
      ST_ARM: begin
        if (fall) begin
          state_n = ST_ADDR;
        end else if (at_limit) begin
          state_n = ST_DONE;
          to_hit  = 1'b1;
        end
      end
      ST_ADDR: begin
        if (rise) begin
          state_n = ST_DATA;
        end else if (at_limit) begin
          state_n = ST_DONE;
          to_hit  = 1'b1;
        end
      end
      ST_DATA: begin
        if (fall) begin
          state_n = ST_DONE;
        end else if (at_limit) begin
          state_n = ST_DONE;
          to_hit  = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Registered state, captured direction, saturating watchdog and sticky error flag
  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      rnw_q     <= 1'b0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      timeout_q <= to_hit;
      if (to_hit) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
      if (state_q == ST_IDLE) begin
        if (bus.req) begin
          rnw_q   <= bus.req_rnw;
          count_q <= '0;
        end
      end else if (active && !at_limit) begin
        count_q <= count_q + TO_W'(1);
      end
    end
  end

  assign bus.cpu_stall    = active;
  assign bus.bbc_cycle_en = in_addr | in_data;
  assign bus.bbc_wdata_oe = in_data & ~rnw_q;
  assign bus.rdata_le     = in_data & rnw_q;
  assign bus.done         = in_done;
  assign bus.timeout      = in_done & timeout_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_bbc_slow_cycle_ctrl.sv
// Self-checking bench for bbc_slow_cycle_ctrl: directed scenarios plus a
// randomized phase/timing sweep, checked against a transaction-level model
// that derives each access from the logged phi0 waveform.
`timescale 1ns/1ps
module tb_bbc_slow_cycle_ctrl;

  localparam int SS   = 2;
  localparam int TO   = 128;
  localparam int MAXC = 8192;
  localparam int BIG  = 1 << 30;

  logic hsclk = 1'b0;
  logic resetb;
  logic bbc_phi0;

  bbc_slow_cycle_ctrl_if bus();

  bbc_slow_cycle_ctrl #(.SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .hsclk    (hsclk),
    .resetb   (resetb),
    .bbc_phi0 (bbc_phi0),
    .bus      (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int rec_n;
  int seg_start;
  logic model_err;

  int  phi_hi    = 8;
  int  phi_lo    = 8;
  bit  phi_stuck = 1'b0;

  logic s_h     [MAXC];
  logic rq_h    [MAXC];
  logic rnw_h   [MAXC];
  logic clr_h   [MAXC];
  logic o_stall [MAXC];
  logic o_en    [MAXC];
  logic o_oe    [MAXC];
  logic o_le    [MAXC];
  logic o_done  [MAXC];
  logic o_to    [MAXC];
  logic o_err   [MAXC];

  // hsclk at 32 MHz
  always #15.625 hsclk = ~hsclk;

  // BBC phi0 generator; changes on hsclk falling edges so it is never sampled mid-transition
  initial begin
    bbc_phi0 = 1'b0;
    forever begin
      if (phi_stuck) begin
        bbc_phi0 = 1'b0;
        @(negedge hsclk);
      end else begin
        bbc_phi0 = 1'b1;
        repeat (phi_hi) @(negedge hsclk);
        bbc_phi0 = 1'b0;
        repeat (phi_lo) @(negedge hsclk);
      end
    end
  end

  // Log inputs at each rising edge and the outputs settled just after it
  always @(posedge hsclk) begin
    rec_n = cyc;
    if (rec_n < MAXC) begin
      s_h[rec_n]   = bbc_phi0;
      rq_h[rec_n]  = bus.req;
      rnw_h[rec_n] = bus.req_rnw;
      clr_h[rec_n] = bus.err_clr;
    end
    #1;
    if (rec_n < MAXC) begin
      o_stall[rec_n] = bus.cpu_stall;
      o_en[rec_n]    = bus.bbc_cycle_en;
      o_oe[rec_n]    = bus.bbc_wdata_oe;
      o_le[rec_n]    = bus.rdata_le;
      o_done[rec_n]  = bus.done;
      o_to[rec_n]    = bus.timeout;
      o_err[rec_n]   = bus.err;
    end
    cyc = rec_n + 1;
  end

  task automatic cmpBit(input string tag, input int n, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s @cycle %0d: observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic checkAll(input int k, input logic st, input logic en, input logic oe,
                          input logic le, input logic dn, input logic to, input logic er);
    cmpBit("cpu_stall",    k, o_stall[k], st);
    cmpBit("bbc_cycle_en", k, o_en[k],    en);
    cmpBit("bbc_wdata_oe", k, o_oe[k],    oe);
    cmpBit("rdata_le",     k, o_le[k],    le);
    cmpBit("done",         k, o_done[k],  dn);
    cmpBit("timeout",      k, o_to[k],    to);
    cmpBit("err",          k, o_err[k],   er);
  endtask

  task automatic checkNowZero(input string tag);
    cmpBit({tag, "_stall"},   cyc, bus.cpu_stall,    1'b0);
    cmpBit({tag, "_en"},      cyc, bus.bbc_cycle_en, 1'b0);
    cmpBit({tag, "_oe"},      cyc, bus.bbc_wdata_oe, 1'b0);
    cmpBit({tag, "_le"},      cyc, bus.rdata_le,     1'b0);
    cmpBit({tag, "_done"},    cyc, bus.done,         1'b0);
    cmpBit({tag, "_timeout"}, cyc, bus.timeout,      1'b0);
    cmpBit({tag, "_err"},     cyc, bus.err,          1'b0);
  endtask

  // The controller sees phi0 SS samples late; these are the edges it acts on at edge m
  function automatic logic fallAt(input int m);
    return s_h[m-SS-1] & ~s_h[m-SS];
  endfunction

  function automatic logic riseAt(input int m);
    return ~s_h[m-SS-1] & s_h[m-SS];
  endfunction

  // Reference model: split the log into accesses; each access needs a phi0 fall, rise, fall
  // in turn, must finish within TO cycles of accept, and is followed by one dead cycle.
  task automatic checkOutput(input int from, input int upto, output int next_n);
    int   n, a, lim, e, stage, f1, r;
    logic to_e, rnwq, erre, hit;
    erre = model_err;
    n    = from;
    while (n <= upto) begin
      if (rq_h[n] !== 1'b1) begin
        if (clr_h[n] === 1'b1) erre = 1'b0;
        checkAll(n, 0, 0, 0, 0, 0, 0, erre);
        n++;
      end else begin
        a     = n;
        rnwq  = rnw_h[a];
        lim   = a + TO;
        stage = 0;
        f1    = BIG;
        r     = BIG;
        e     = -1;
        to_e  = 1'b0;
        for (int m = a + 1; m <= upto && e < 0; m++) begin
          hit = (stage == 1) ? riseAt(m) : fallAt(m);
          if (hit === 1'b1) begin
            stage++;
            if (stage == 1)      f1 = m;
            else if (stage == 2) r  = m;
            else                 e  = m;
          end else if (m >= lim) begin
            e    = m;
            to_e = 1'b1;
          end
        end
        if (e < 0) e = BIG;
        for (int k = a; k <= upto && k <= e + 1; k++) begin
          if (k == e && to_e)        erre = 1'b1;
          else if (clr_h[k] === 1'b1) erre = 1'b0;
          checkAll(k, k < e, (k >= f1) && (k < e),
                   (k >= r) && (k < e) && !rnwq, (k >= r) && (k < e) && rnwq,
                   k == e, (k == e) && to_e, erre);
        end
        n = (e == BIG) ? upto + 1 : e + 2;
      end
    end
    model_err = erre;
    next_n    = n;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge hsclk);
  endtask

  task automatic waitPhi(input logic lvl);
    int w;
    w = 0;
    while (bbc_phi0 !== lvl && w < 300) begin
      @(negedge hsclk);
      w++;
    end
    tests_run++;
    assert (w < 300) else begin
      tests_failed++;
      $error("[TB] FAIL phi0_wait: observed %0d cycles without level %b, required < 300", w, lvl);
    end
  endtask

  // Raise req (optionally toggling req_rnw mid-access) and drop it on done, or on the second done when held
  task automatic applyStimulus(input logic rnw, input bit hold, input bit toggle_rnw);
    int w;
    @(negedge hsclk);
    bus.req     = 1'b1;
    bus.req_rnw = rnw;
    for (int d = 0; d < (hold ? 2 : 1); d++) begin
      w = 0;
      do begin
        @(negedge hsclk);
        w++;
        if (toggle_rnw) bus.req_rnw = ~bus.req_rnw;
      end while (bus.done !== 1'b1 && w < 400);
      tests_run++;
      assert (w < 400) else begin
        tests_failed++;
        $error("[TB] FAIL done_wait: observed %0d cycles without done, required < 400", w);
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic pulseErrClr();
    @(negedge hsclk);
    bus.err_clr = 1'b1;
    @(negedge hsclk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    int w;
    logic rnd_rnw;
    bit   rnd_hold, rnd_tog;

    resetb      = 1'b0;
    bus.req     = 1'b0;
    bus.req_rnw = 1'b0;
    bus.err_clr = 1'b0;
    model_err   = 1'b0;

    waitCycles(4);
    checkNowZero("reset");
    resetb = 1'b1;
    waitCycles(6);
    seg_start = cyc;

    // Read started while phi0 is high
    $display("[TB] read with phi0 high");
    waitPhi(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(3);

    // Write raised just after a phi0 fall
    $display("[TB] write just after phi0 fall");
    waitPhi(1'b1);
    waitPhi(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput(seg_start, cyc - 1, seg_start);

    // phi0 stuck low: watchdog abort, sticky err, then clear and recover
    $display("[TB] phi0 stuck low");
    phi_stuck = 1'b1;
    waitCycles(40);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(3);
    cmpBit("err_sticky", cyc, bus.err, 1'b1);
    pulseErrClr();
    cmpBit("err_after_clr", cyc, bus.err, 1'b0);
    phi_stuck = 1'b0;
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput(seg_start, cyc - 1, seg_start);

    // Stretched phi2 with req_rnw toggling during the access
    $display("[TB] stretched phi2");
    phi_hi = 48;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    phi_hi = 8;
    waitCycles(3);
    checkOutput(seg_start, cyc - 1, seg_start);

    // Back-to-back accesses with req held through done
    $display("[TB] req held through done");
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput(seg_start, cyc - 1, seg_start);

    // Reset during DATA abandons the access with no done
    $display("[TB] reset during DATA");
    @(negedge hsclk);
    bus.req     = 1'b1;
    bus.req_rnw = 1'b0;
    w = 0;
    while (bus.bbc_wdata_oe !== 1'b1 && w < 300) begin
      @(negedge hsclk);
      w++;
    end
    tests_run++;
    assert (w < 300) else begin
      tests_failed++;
      $error("[TB] FAIL data_wait: observed %0d cycles without DATA, required < 300", w);
    end
    checkOutput(seg_start, cyc - 1, seg_start);
    resetb  = 1'b0;
    bus.req = 1'b0;
    @(negedge hsclk);
    checkNowZero("mid_reset");
    resetb    = 1'b1;
    model_err = 1'b0;
    waitCycles(6);
    seg_start = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput(seg_start, cyc - 1, seg_start);

    // Randomized phase, phi0 widths (some long enough to time out), gaps and direction
    $display("[TB] randomized accesses");
    for (int i = 0; i < 20; i++) begin
      phi_hi   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 75)) : int'($urandom_range(4, 16));
      phi_lo   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 75)) : int'($urandom_range(4, 16));
      rnd_rnw  = 1'($urandom_range(0, 1));
      rnd_hold = ($urandom_range(0, 3) == 0);
      rnd_tog  = 1'($urandom_range(0, 1));
      waitCycles($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) pulseErrClr();
      applyStimulus(rnd_rnw, rnd_hold, rnd_tog);
    end
    waitCycles(4);
    checkOutput(seg_start, cyc - 1, seg_start);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
